// File: rtl/core_dmem_arbiter_if.sv
// Bus bundle between the per-hart load/store channels, the shared data-memory
// port and the arbiter; the arbiter uses the slave view, the environment the master view.
interface core_dmem_arbiter_if #(
  parameter int NUM_HARTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int GID_WIDTH  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
);
  logic [NUM_HARTS-1:0]            io_req_valid;
  logic [NUM_HARTS-1:0]            io_req_ready;
  logic [NUM_HARTS*ADDR_WIDTH-1:0] io_req_addr;
  logic [NUM_HARTS-1:0]            io_req_wen;
  logic [NUM_HARTS*DATA_WIDTH-1:0] io_req_wdata;
  logic [NUM_HARTS*MASK_WIDTH-1:0] io_req_wmask;
  logic [NUM_HARTS-1:0]            io_resp_valid;
  logic [DATA_WIDTH-1:0]           io_resp_rdata;
  logic                            io_resp_err;
  logic                            io_mem_req_valid;
  logic                            io_mem_req_ready;
  logic [ADDR_WIDTH-1:0]           io_mem_addr;
  logic                            io_mem_wen;
  logic [DATA_WIDTH-1:0]           io_mem_wdata;
  logic [MASK_WIDTH-1:0]           io_mem_wmask;
  logic                            io_mem_resp_valid;
  logic [DATA_WIDTH-1:0]           io_mem_resp_rdata;
  logic [GID_WIDTH-1:0]            io_grant_id;
  logic                            io_busy;

  modport slave (
    input  io_req_valid, io_req_addr, io_req_wen, io_req_wdata, io_req_wmask,
    input  io_mem_req_ready, io_mem_resp_valid, io_mem_resp_rdata,
    output io_req_ready, io_resp_valid, io_resp_rdata, io_resp_err,
    output io_mem_req_valid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wmask,
    output io_grant_id, io_busy
  );

  modport master (
    output io_req_valid, io_req_addr, io_req_wen, io_req_wdata, io_req_wmask,
    output io_mem_req_ready, io_mem_resp_valid, io_mem_resp_rdata,
    input  io_req_ready, io_resp_valid, io_resp_rdata, io_resp_err,
    input  io_mem_req_valid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wmask,
    input  io_grant_id, io_busy
  );
endinterface

// File: rtl/core_dmem_arbiter.sv
// Round-robin arbiter funnelling per-hart load/store channels onto one data-memory
// port, one transaction in flight, with a read-response timeout that flags an error.
module core_dmem_arbiter #(
  parameter int NUM_HARTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 255,
  parameter int GID_WIDTH  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  core_dmem_arbiter_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [GID_WIDTH-1:0] GID_LAST = GID_WIDTH'(NUM_HARTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [GID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [GID_WIDTH-1:0]  grant_id_q, grant_id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  any_found_s, hi_found_s, grant_valid_s;
  logic [GID_WIDTH-1:0]  any_id_s, hi_id_s, grant_id_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic                  sel_wen_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [MASK_WIDTH-1:0] sel_wmask_s;
  logic [NUM_HARTS-1:0]  req_ready_s, resp_valid_s;

  // Round-robin pick: lowest valid hart at or above rr_ptr, else lowest valid overall.
  always_comb begin
    any_found_s = 1'b0;
    any_id_s    = '0;
    hi_found_s  = 1'b0;
    hi_id_s     = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      any_found_s = any_found_s | bus.io_req_valid[h];
      any_id_s    = bus.io_req_valid[h] ? GID_WIDTH'(h) : any_id_s;
      hi_found_s  = hi_found_s | (bus.io_req_valid[h] & (GID_WIDTH'(h) >= rr_ptr_q));
      hi_id_s     = (bus.io_req_valid[h] && (GID_WIDTH'(h) >= rr_ptr_q)) ? GID_WIDTH'(h) : hi_id_s;
    end
    grant_valid_s = any_found_s;
    grant_id_s    = hi_found_s ? hi_id_s : any_id_s;
  end

  // Mux the granted hart's request fields out of the flattened buses.
  always_comb begin
    sel_addr_s  = '0;
    sel_wen_s   = 1'b0;
    sel_wdata_s = '0;
    sel_wmask_s = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      sel_addr_s  = (grant_id_s == GID_WIDTH'(h)) ? bus.io_req_addr[h*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
      sel_wen_s   = (grant_id_s == GID_WIDTH'(h)) ? bus.io_req_wen[h] : sel_wen_s;
      sel_wdata_s = (grant_id_s == GID_WIDTH'(h)) ? bus.io_req_wdata[h*DATA_WIDTH +: DATA_WIDTH] : sel_wdata_s;
      sel_wmask_s = (grant_id_s == GID_WIDTH'(h)) ? bus.io_req_wmask[h*MASK_WIDTH +: MASK_WIDTH] : sel_wmask_s;
    end
  end

  // Transaction sequencing: next state, latched request, response data and timeout count.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          grant_id_d = grant_id_s;
          addr_d     = sel_addr_s;
          wen_d      = sel_wen_s;
          wdata_d    = sel_wdata_s;
          wmask_d    = sel_wmask_s;
          rr_ptr_d   = (grant_id_s == GID_LAST) ? '0 : grant_id_s + GID_WIDTH'(1);
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.io_mem_req_ready) begin
          if (wen_q) begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = ST_ACK;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A response arriving on the last allowed cycle beats the timeout.
        if (bus.io_mem_resp_valid) begin
          rdata_d = bus.io_mem_resp_rdata;
          err_d   = 1'b0;
          state_d = ST_ACK;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Per-hart ready (held low while reset is asserted) and completion pulse decode.
  always_comb begin
    req_ready_s  = '0;
    resp_valid_s = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      req_ready_s[h]  = rst && (state_q == ST_IDLE) && grant_valid_s && (grant_id_s == GID_WIDTH'(h));
      resp_valid_s[h] = (state_q == ST_ACK) && (grant_id_q == GID_WIDTH'(h));
    end
  end

  assign bus.io_req_ready     = req_ready_s;
  assign bus.io_resp_valid    = resp_valid_s;
  assign bus.io_resp_rdata    = rdata_q;
  assign bus.io_resp_err      = err_q;
  assign bus.io_mem_req_valid = (state_q == ST_ISSUE);
  assign bus.io_mem_addr      = addr_q;
  assign bus.io_mem_wen       = wen_q;
  assign bus.io_mem_wdata     = wdata_q;
  assign bus.io_mem_wmask     = wmask_q;
  assign bus.io_grant_id      = grant_id_q;
  assign bus.io_busy          = (state_q != ST_IDLE);
endmodule

// File: tb/tb_core_dmem_arbiter.sv
// Directed bench for core_dmem_arbiter: a transaction-level model is compared with the
// DUT every cycle, and literal expectations pin the key timings and values.
module tb_core_dmem_arbiter;
  localparam int NH = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  core_dmem_arbiter_if #(.NUM_HARTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dif ();

  core_dmem_arbiter #(
    .NUM_HARTS(NH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  // model state: phase 0 idle, 1 issuing, 2 waiting for data, 3 acknowledging
  int              m_phase, m_owner, m_rr, m_waited;
  logic            m_wen, m_err;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata, m_rdata;
  logic [MW-1:0]   m_wmask;
  logic [NH-1:0]   exp_ready;
  logic [NH-1:0]   resp_log[$];
  int              g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int h, input logic v, input logic wen, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    dif.io_req_valid[h]          = v;
    dif.io_req_wen[h]            = wen;
    dif.io_req_addr[h*AW +: AW]  = a;
    dif.io_req_wdata[h*DW +: DW] = d;
    dif.io_req_wmask[h*MW +: MW] = m;
  endtask

  function automatic int pick_hart();
    for (int k = 0; k < NH; k++) begin
      automatic int h = (m_rr + k) % NH;
      if (dif.io_req_valid[h]) return h;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_rr = 0; m_waited = 0;
    m_wen = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_wmask = '0;
  endtask

  task automatic model_advance(input int gh);
    case (m_phase)
      0: if (gh >= 0) begin
        m_owner = gh;
        m_rr    = (gh + 1) % NH;
        m_addr  = dif.io_req_addr[gh*AW +: AW];
        m_wen   = dif.io_req_wen[gh];
        m_wdata = dif.io_req_wdata[gh*DW +: DW];
        m_wmask = dif.io_req_wmask[gh*MW +: MW];
        m_phase = 1;
      end
      1: if (dif.io_mem_req_ready) begin
        if (m_wen) begin
          m_rdata = '0; m_err = 1'b0; m_phase = 3;
        end else begin
          m_waited = 0; m_phase = 2;
        end
      end
      2: if (dif.io_mem_resp_valid) begin
        m_rdata = dif.io_mem_resp_rdata; m_err = 1'b0; m_phase = 3;
      end else begin
        m_waited++;
        if (TO != 0 && m_waited == TO) begin
          m_rdata = '0; m_err = 1'b1; m_phase = 3;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  // every-cycle comparison against the model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) model_reset();
      g = pick_hart();
      exp_ready = '0;
      if (rst && m_phase == 0 && g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", 64'(dif.io_req_ready), 64'(exp_ready));
      check("mem_req_valid", 64'(dif.io_mem_req_valid), 64'(m_phase == 1));
      check("mem_addr", 64'(dif.io_mem_addr), 64'(m_addr));
      check("mem_wen", 64'(dif.io_mem_wen), 64'(m_wen));
      check("mem_wdata", 64'(dif.io_mem_wdata), 64'(m_wdata));
      check("mem_wmask", 64'(dif.io_mem_wmask), 64'(m_wmask));
      check("grant_id", 64'(dif.io_grant_id), 64'(m_owner));
      check("busy", 64'(dif.io_busy), 64'(m_phase != 0));
      check("resp_valid", 64'(dif.io_resp_valid), (m_phase == 3) ? (64'd1 << m_owner) : 64'd0);
      if (m_phase == 3) begin
        check("resp_rdata", 64'(dif.io_resp_rdata), 64'(m_rdata));
        check("resp_err", 64'(dif.io_resp_err), 64'(m_err));
      end
      if (dif.io_resp_valid != '0) resp_log.push_back(dif.io_resp_valid);
      if (rst) model_advance(g);
    end
  end

  logic [NH-1:0] rr_exp [4];

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b0;
    dif.io_req_valid = '0; dif.io_req_wen = '0; dif.io_req_addr = '0;
    dif.io_req_wdata = '0; dif.io_req_wmask = '0;
    dif.io_mem_req_ready = 1'b0; dif.io_mem_resp_valid = 1'b0; dif.io_mem_resp_rdata = '0;
    set_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    tick(); tick();
    check("rst_ready", 64'(dif.io_req_ready), 64'd0);
    check("rst_busy", 64'(dif.io_busy), 64'd0);
    check("rst_grant", 64'(dif.io_grant_id), 64'd0);
    check("rst_mem_valid", 64'(dif.io_mem_req_valid), 64'd0);
    check("rst_resp", 64'(dif.io_resp_valid), 64'd0);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b1;
    tick();

    // single load from hart0
    dif.io_mem_req_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("s1_mem_valid", 64'(dif.io_mem_req_valid), 64'd1);
    check("s1_mem_addr", 64'(dif.io_mem_addr), 64'h100);
    tick();
    dif.io_mem_resp_valid = 1'b1; dif.io_mem_resp_rdata = 32'hCAFE_BABE;
    tick();
    dif.io_mem_resp_valid = 1'b0; dif.io_mem_resp_rdata = 32'h0;
    check("s1_resp_valid", 64'(dif.io_resp_valid), 64'h1);
    check("s1_rdata", 64'(dif.io_resp_rdata), 64'hCAFE_BABE);
    check("s1_err", 64'(dif.io_resp_err), 64'd0);
    tick();
    check("s1_idle", 64'(dif.io_busy), 64'd0);

    // store from hart1 with memory ready held off for three cycles
    dif.io_mem_req_ready = 1'b0;
    set_req(1, 1'b1, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'h3);
    tick();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      check("s2_hold_valid", 64'(dif.io_mem_req_valid), 64'd1);
      check("s2_hold_addr", 64'(dif.io_mem_addr), 64'h40);
      check("s2_hold_wdata", 64'(dif.io_mem_wdata), 64'h1122_3344);
      check("s2_hold_wmask", 64'(dif.io_mem_wmask), 64'h3);
      tick();
    end
    dif.io_mem_req_ready = 1'b1;
    tick();
    check("s2_resp_valid", 64'(dif.io_resp_valid), 64'h2);
    check("s2_rdata", 64'(dif.io_resp_rdata), 64'd0);
    tick();

    // both harts continuously requesting: completions must alternate
    resp_log.delete();
    set_req(0, 1'b1, 1'b1, 32'h0000_0010, 32'hA0A0_A0A0, 4'hF);
    set_req(1, 1'b1, 1'b1, 32'h0000_0014, 32'hB1B1_B1B1, 4'hF);
    repeat (12) tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("s3_count", 64'(resp_log.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < resp_log.size()) check("s3_order", 64'(resp_log[i]), 64'(rr_exp[i]));
    end
    tick();

    // load from hart1 that memory never answers
    set_req(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0);
    tick();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    repeat (3) tick();
    check("s4_still_waiting", 64'(dif.io_resp_valid), 64'd0);
    tick();
    check("s4_resp_valid", 64'(dif.io_resp_valid), 64'h2);
    check("s4_err", 64'(dif.io_resp_err), 64'd1);
    check("s4_rdata", 64'(dif.io_resp_rdata), 64'd0);
    set_req(0, 1'b1, 1'b1, 32'h0000_0044, 32'h5566_7788, 4'hC);
    tick();
    check("s4_next_ready", 64'(dif.io_req_ready), 64'h1);
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("s4_next_grant", 64'(dif.io_grant_id), 64'd0);
    tick();
    check("s4_next_resp", 64'(dif.io_resp_valid), 64'h1);
    check("s4_next_err", 64'(dif.io_resp_err), 64'd0);
    tick();

    // response arriving on the final wait cycle beats the timeout
    set_req(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick(); tick(); tick();
    dif.io_mem_resp_valid = 1'b1; dif.io_mem_resp_rdata = 32'h5A5A_5A5A;
    tick();
    dif.io_mem_resp_valid = 1'b0; dif.io_mem_resp_rdata = 32'h0;
    check("s5_resp_valid", 64'(dif.io_resp_valid), 64'h1);
    check("s5_err", 64'(dif.io_resp_err), 64'd0);
    check("s5_rdata", 64'(dif.io_resp_rdata), 64'h5A5A_5A5A);
    tick();

    // reset while waiting, then a late memory response
    set_req(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    tick();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    check("s6_in_wait", 64'(dif.io_busy), 64'd1);
    rst = 1'b0;
    #1;
    check("s6_rst_busy", 64'(dif.io_busy), 64'd0);
    check("s6_rst_grant", 64'(dif.io_grant_id), 64'd0);
    check("s6_rst_addr", 64'(dif.io_mem_addr), 64'd0);
    tick();
    rst = 1'b1;
    dif.io_mem_resp_valid = 1'b1; dif.io_mem_resp_rdata = 32'hDEAD_BEEF;
    tick();
    dif.io_mem_resp_valid = 1'b0; dif.io_mem_resp_rdata = 32'h0;
    check("s6_no_resp", 64'(dif.io_resp_valid), 64'd0);
    check("s6_idle", 64'(dif.io_busy), 64'd0);
    set_req(0, 1'b1, 1'b1, 32'h0000_0050, 32'h0101_0101, 4'h1);
    set_req(1, 1'b1, 1'b1, 32'h0000_0054, 32'h0202_0202, 4'h2);
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("s6_first_grant", 64'(dif.io_grant_id), 64'd0);
    tick();
    tick();
    tick();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("s6_second_grant", 64'(dif.io_grant_id), 64'd1);
    tick();
    check("s6_second_resp", 64'(dif.io_resp_valid), 64'h2);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/core_dmem_arbiter.md
Name: core_dmem_arbiter

Overview:
- Parametrised data-memory front end for multi-hart BA20X builds.
- Arbitrates NUM_HARTS per-hart load/store request channels onto one shared data-memory port using valid/ready.
- Memory read latency may be variable; the block routes each response back to the issuing hart.
- Adds round-robin fairness, write acknowledge and a response timeout with error signalling. The single-hart, zero-latency dmem path has none of these.

Parameters:
- NUM_HARTS, 2, number of requesting harts (≥1).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- MASK_WIDTH, DATA_WIDTH/8, byte write-mask width.
- TIMEOUT, 255, maximum cycles waiting for a read response; 0 disables the timeout.
- GID_WIDTH, max(1,clog2(NUM_HARTS)), grant id width.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- io_req_valid  in  NUM_HARTS  per-hart request valid.
- io_req_ready  out  NUM_HARTS  per-hart request accepted.
- io_req_addr  in  NUM_HARTS*ADDR_WIDTH  flattened addresses; hart h occupies slice h.
- io_req_wen  in  NUM_HARTS  1 = store, 0 = load.
- io_req_wdata  in  NUM_HARTS*DATA_WIDTH  flattened store data.
- io_req_wmask  in  NUM_HARTS*MASK_WIDTH  flattened byte masks.
- io_resp_valid  out  NUM_HARTS  one-cycle completion pulse to the owning hart.
- io_resp_rdata  out  DATA_WIDTH  load data, shared, qualified by io_resp_valid.
- io_resp_err  out  1  timeout flag, qualified by io_resp_valid.
- io_mem_req_valid  out  1  memory request valid.
- io_mem_req_ready  in  1  memory accepts request.
- io_mem_addr / io_mem_wen / io_mem_wdata / io_mem_wmask  out  ADDR_WIDTH/1/DATA_WIDTH/MASK_WIDTH  latched request fields.
- io_mem_resp_valid  in  1  read data valid.
- io_mem_resp_rdata  in  DATA_WIDTH  read data.
- io_grant_id  out  GID_WIDTH  hart currently owning the port.
- io_busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0, timeout counter=0.
  - All outputs 0, including latched request fields and io_grant_id.
  - An in-flight transaction is abandoned with no response. A late io_mem_resp_valid after reset is ignored.
- States: IDLE, ISSUE, WAIT, ACK. One outstanding transaction at a time.
- IDLE:
  - Grant g = first h with io_req_valid[h]=1, searching from rr_ptr upward and wrapping modulo NUM_HARTS.
  - io_req_ready[g]=1 combinationally in the same cycle; all other ready bits 0.
  - On the clock edge: latch addr/wen/wdata/wmask of g; io_grant_id<=g; rr_ptr<=(g+1) mod NUM_HARTS; go to ISSUE.
  - No valid requests: stay in IDLE, rr_ptr unchanged.
- ISSUE:
  - io_mem_req_valid=1; fields held stable until io_mem_req_ready=1.
  - On handshake: wen=1 goes to ACK; wen=0 goes to WAIT with counter cleared.
- WAIT:
  - io_mem_resp_valid=1: register io_mem_resp_rdata, err=0, go to ACK.
  - Otherwise the counter increments. If TIMEOUT≠0 and counter reaches TIMEOUT-1 without a response: rdata=0, err=1, go to ACK.
  - io_mem_resp_valid while not in WAIT is ignored.
  - io_mem_resp_valid in the same cycle the timeout fires: the response wins (err=0).
- ACK:
  - io_resp_valid[io_grant_id]=1 for exactly one cycle, with registered rdata and err.
  - Store acks drive rdata=0, err=0.
  - Then go to IDLE. No new grant is made in ACK.
- Latency, with memory ready and resp immediate:
  - Load: accept cycle 0, issue cycle 1, resp sampled cycle 2, io_resp_valid cycle 3.
  - Store: io_resp_valid cycle 2.
- A requester keeps io_req_valid and its fields stable until io_req_ready. The block does not re-sample after acceptance.
- NUM_HARTS=1: rr_ptr is constant 0 and io_grant_id is 0.

Test Plan:
- Single load: hart0 reads addr 0x100, memory ready immediately, resp 0xCAFEBABE next cycle → io_resp_valid[0] at cycle 3, rdata=0xCAFEBABE, err=0.
- Store ack: hart1 stores 0x11223344 with mask 0x3 at 0x40; io_mem_req_ready delayed 3 cycles → mem fields stable for those cycles, io_resp_valid[1] one cycle after the handshake, rdata=0.
- Round-robin: both harts continuously valid from reset → grants alternate 0,1,0,1 over 4 transactions; no hart starves.
- Timeout: TIMEOUT=4, memory never responds → io_resp_valid pulses with err=1, rdata=0 after 4 WAIT cycles; the next request is then granted normally.
- Response/timeout race: io_mem_resp_valid with 0x5A5A5A5A arrives in the final WAIT cycle → err=0, data delivered.
- Reset mid-WAIT: deassert rst during WAIT, then inject io_mem_resp_valid → no io_resp_valid, io_busy=0, rr_ptr=0, next grant goes to hart0.
